// File: rtl/ctrl_595_pkg.sv
// Shared types and helpers for the 74HC595 chain driver.
package ctrl_595_pkg;

    localparam int unsigned MAX_BITS = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    // word is left-justified for MSB-first and right-justified for LSB-first,
    // so idx is always the serial position within the frame.
    function automatic logic bit_sel(input logic [MAX_BITS-1:0] word,
                                     input logic [5:0]          idx,
                                     input logic                lsb_first);
        return lsb_first ? word[idx] : word[6'(MAX_BITS - 1) - idx];
    endfunction

    function automatic bit params_ok(input int unsigned n_bits, input int unsigned clk_div);
        return (n_bits >= 1) && (n_bits <= MAX_BITS) && (clk_div >= 2) && (clk_div % 2 == 0);
    endfunction

endpackage

// File: rtl/ctrl_595_chain_sclk_div.sv
// Serial bit-period divider: counts 0..CLK_DIV-1 while running, held at 0 otherwise.
module sclk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick_c,
    output logic hi_next_c,
    output logic pre_tick_c
);

    localparam int unsigned DW   = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HALF = CLK_DIV / 2;

    logic [DW-1:0] cnt;
    logic [DW:0]   cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DW'(1);
        end
    end

    // hi_next_c: the following cycle lies in the second half of the period
    assign cnt_nxt    = {1'b0, cnt} + (DW + 1)'(1);
    assign tick_c     = (cnt == DW'(CLK_DIV - 1));
    assign hi_next_c  = (cnt_nxt >= (DW + 1)'(HALF)) && !tick_c;
    assign pre_tick_c = (cnt == DW'(CLK_DIV - 2));

endmodule

// File: rtl/ctrl_595_chain.sv
// Serial driver for a daisy-chain of 74HC595s: shadow register, shift FSM and latch pulse.
module ctrl_595_chain
    import ctrl_595_pkg::*;
#(
    parameter int unsigned N_BITS       = 14,
    parameter int unsigned CLK_DIV      = 4,
    parameter bit          LSB_FIRST    = 1'b0,
    parameter bit          AUTO_REFRESH = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BITS-1:0] din,
    input  logic              load,
    output logic              load_ready,
    output logic              frame_done,
    output logic              busy,
    output logic              oe_595,
    output logic              shcp_595,
    output logic              stcp_595,
    output logic              ds
);

    localparam int unsigned   BW       = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(N_BITS - 1);
    localparam int unsigned   PAD      = MAX_BITS - N_BITS;

    if (!params_ok(N_BITS, CLK_DIV)) begin : g_bad_params
        $error("ctrl_595_chain: N_BITS must be 1..64 and CLK_DIV even and >= 2");
    end

    function automatic logic [MAX_BITS-1:0] align(input logic [N_BITS-1:0] w);
        return LSB_FIRST ? MAX_BITS'(w) : (MAX_BITS'(w) << PAD);
    endfunction

    state_t            state, state_d;
    logic [N_BITS-1:0] shadow, shadow_d, active, active_d;
    logic [BW-1:0]     bit_cnt, bit_d;
    logic              pending, pending_d;
    logic              ready_d, done_d, busy_d, oe_d, shcp_d, stcp_d, ds_d;
    logic              accept_c, start_c;
    logic              tick_c, hi_next_c, pre_tick_c;

    sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (state != IDLE),
        .tick_c     (tick_c),
        .hi_next_c  (hi_next_c),
        .pre_tick_c (pre_tick_c)
    );

    always_comb begin
        state_d   = state;
        shadow_d  = shadow;
        active_d  = active;
        pending_d = pending;
        bit_d     = bit_cnt;
        ds_d      = ds;
        oe_d      = oe_595;
        shcp_d    = 1'b0;
        stcp_d    = 1'b0;
        done_d    = 1'b0;
        start_c   = 1'b0;
        accept_c  = load && load_ready;

        if (accept_c) begin
            shadow_d = din;
        end

        case (state)
            IDLE: begin
                if (pending) begin
                    start_c = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shcp_d = hi_next_c;
                if (tick_c) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_d = LATCH;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_cnt + BW'(1);
                        ds_d  = bit_sel(align(active), 6'(bit_cnt) + 6'd1, LSB_FIRST);
                    end
                end
            end
            LATCH: begin
                stcp_d = hi_next_c;
                done_d = pre_tick_c;
                if (tick_c) begin
                    oe_d = 1'b0;
                    if (AUTO_REFRESH || pending) begin
                        start_c = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // frame start always takes the pre-edge shadow, never this cycle's din
        if (start_c) begin
            active_d  = shadow;
            ds_d      = bit_sel(align(shadow), 6'd0, LSB_FIRST);
            pending_d = 1'b0;
        end
        if (accept_c) begin
            pending_d = 1'b1;
        end

        ready_d = AUTO_REFRESH ? 1'b1 : ~pending_d;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            bit_cnt    <= '0;
            load_ready <= 1'b1;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            oe_595     <= 1'b1;
            shcp_595   <= 1'b0;
            stcp_595   <= 1'b0;
            ds         <= 1'b0;
        end else begin
            state      <= state_d;
            shadow     <= shadow_d;
            active     <= active_d;
            pending    <= pending_d;
            bit_cnt    <= bit_d;
            load_ready <= ready_d;
            frame_done <= done_d;
            busy       <= busy_d;
            oe_595     <= oe_d;
            shcp_595   <= shcp_d;
            stcp_595   <= stcp_d;
            ds         <= ds_d;
        end
    end

endmodule

// File: tb/tb_ctrl_595_chain.sv
// Bench for ctrl_595_chain: directed timing checks plus a random 595-chain model comparison.
module tb_ctrl_595_chain;

    localparam int unsigned NI       = 5;
    localparam logic [63:0] IDLE_VEC = 64'h3;

    logic clk = 1'b0;
    logic rst_n;
    logic [NI-1:0] load_v, ready_v, done_v, busy_v, oe_v, shcp_v, stcp_v, ds_v;
    logic [13:0] din0;
    logic [7:0]  din1;
    logic [0:0]  din2;
    logic [15:0] din3;
    logic [63:0] din4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ctrl_595_chain u_def (
        .clk(clk), .rst_n(rst_n), .din(din0), .load(load_v[0]), .load_ready(ready_v[0]),
        .frame_done(done_v[0]), .busy(busy_v[0]), .oe_595(oe_v[0]), .shcp_595(shcp_v[0]),
        .stcp_595(stcp_v[0]), .ds(ds_v[0]));

    ctrl_595_chain #(.N_BITS(8), .CLK_DIV(2), .LSB_FIRST(1'b1), .AUTO_REFRESH(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .din(din1), .load(load_v[1]), .load_ready(ready_v[1]),
        .frame_done(done_v[1]), .busy(busy_v[1]), .oe_595(oe_v[1]), .shcp_595(shcp_v[1]),
        .stcp_595(stcp_v[1]), .ds(ds_v[1]));

    ctrl_595_chain #(.N_BITS(1), .CLK_DIV(2), .LSB_FIRST(1'b0), .AUTO_REFRESH(1'b0)) u_r1 (
        .clk(clk), .rst_n(rst_n), .din(din2), .load(load_v[2]), .load_ready(ready_v[2]),
        .frame_done(done_v[2]), .busy(busy_v[2]), .oe_595(oe_v[2]), .shcp_595(shcp_v[2]),
        .stcp_595(stcp_v[2]), .ds(ds_v[2]));

    ctrl_595_chain #(.N_BITS(16), .CLK_DIV(6), .LSB_FIRST(1'b0), .AUTO_REFRESH(1'b1)) u_r16 (
        .clk(clk), .rst_n(rst_n), .din(din3), .load(load_v[3]), .load_ready(ready_v[3]),
        .frame_done(done_v[3]), .busy(busy_v[3]), .oe_595(oe_v[3]), .shcp_595(shcp_v[3]),
        .stcp_595(stcp_v[3]), .ds(ds_v[3]));

    ctrl_595_chain #(.N_BITS(64), .CLK_DIV(2), .LSB_FIRST(1'b0), .AUTO_REFRESH(1'b1)) u_r64 (
        .clk(clk), .rst_n(rst_n), .din(din4), .load(load_v[4]), .load_ready(ready_v[4]),
        .frame_done(done_v[4]), .busy(busy_v[4]), .oe_595(oe_v[4]), .shcp_595(shcp_v[4]),
        .stcp_595(stcp_v[4]), .ds(ds_v[4]));

    // Physical 595 chain: shift on shcp rise, copy to outputs on stcp rise.
    for (genvar g = 0; g < NI; g++) begin : g_mdl
        logic [63:0] sr      = '0;
        logic [63:0] q       = '0;
        int          shifts  = 0;
        int          latches = 0;
        always @(posedge shcp_v[g]) begin
            sr     <= {sr[62:0], ds_v[g]};
            shifts <= shifts + 1;
        end
        always @(posedge stcp_v[g]) begin
            q       <= sr;
            latches <= latches + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ovec(input int i);
        return 64'({busy_v[i], shcp_v[i], stcp_v[i], ds_v[i], done_v[i], oe_v[i], ready_v[i]});
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = x[7 - b];
        return r;
    endfunction

    task automatic wait_done(input int idx, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_v[idx] && n < 2000);
        check(tag, 64'(done_v[idx]), 64'd1);
    endtask

    logic [13:0] w0, w1;
    logic [7:0]  d2;
    logic [6:0]  ev;
    logic [63:0] exp2[$], exp3[$], exp4[$];
    int sh0, lat0, nbusy, ndone, n2, n3, n4, r, c, k, d;

    initial begin
        rst_n  = 1'b0;
        load_v = '0;
        din0 = '0; din1 = '0; din2 = '0; din3 = '0; din4 = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) check("reset_outputs", ovec(i), IDLE_VEC);
        rst_n = 1'b1;

        // no load: chain stays quiet and blanked
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_no_load", ovec(0), IDLE_VEC);
        end

        // defaults, 14'h2A5C: exact per-cycle waveform over two refresh frames
        w0 = 14'h2A5C;
        din0 = w0;
        load_v[0] = 1'b1;
        sh0 = g_mdl[0].shifts;
        @(negedge clk);
        load_v[0] = 1'b0;
        for (int i = 0; i <= 120; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) begin
                ev = 7'b0000011;
            end else begin
                r = i - 1; c = r % 60; k = c / 4; d = c % 4;
                ev[6] = 1'b1;
                ev[5] = (c < 56) && (d >= 2);
                ev[4] = (c >= 56) && (d >= 2);
                ev[3] = (c < 56) ? w0[13 - k] : w0[0];
                ev[2] = (c == 59);
                ev[1] = (r < 60);
                ev[0] = 1'b1;
            end
            check("frame_wave_def", ovec(0), 64'(ev));
            if (i == 60) begin
                check("shcp_rises_def", 64'(g_mdl[0].shifts - sh0), 64'd14);
                check("latched_def", 64'(g_mdl[0].q[13:0]), 64'(w0));
            end
        end

        // load B exactly on the LATCH->SHIFT edge: A once more, then B
        w1 = 14'($urandom);
        if (w1 == w0) w1 = ~w0;
        din0 = w1;
        load_v[0] = 1'b1;
        @(negedge clk);
        load_v[0] = 1'b0;
        wait_done(0, "done_a");
        check("frame_keeps_a", 64'(g_mdl[0].q[13:0]), 64'(w0));
        wait_done(0, "done_b");
        check("frame_takes_b", 64'(g_mdl[0].q[13:0]), 64'(w1));

        // LSB-first one-shot mode with handshake back-pressure
        din1 = 8'hC1;
        check("lsb_ready_idle", 64'(ready_v[1]), 64'd1);
        load_v[1] = 1'b1;
        @(negedge clk);
        load_v[1] = 1'b0;
        nbusy = 0;
        ndone = 0;
        @(negedge clk);
        if (busy_v[1]) nbusy++;
        check("lsb_busy_start", 64'(busy_v[1]), 64'd1);
        check("lsb_ready_shift", 64'(ready_v[1]), 64'd1);
        d2 = 8'($urandom);
        din1 = d2;
        load_v[1] = 1'b1;
        @(negedge clk);
        if (busy_v[1]) nbusy++;
        check("lsb_ready_pending", 64'(ready_v[1]), 64'd0);
        din1 = ~d2;
        @(negedge clk);
        if (busy_v[1]) nbusy++;
        load_v[1] = 1'b0;
        for (int j = 3; j < 60; j++) begin
            @(negedge clk);
            if (busy_v[1]) nbusy++;
            if (done_v[1]) begin
                ndone++;
                if (ndone == 1) begin
                    check("lsb_done_pos1", 64'(j), 64'd17);
                    check("lsb_frame1", 64'(g_mdl[1].q[7:0]), 64'(rev8(8'hC1)));
                end else if (ndone == 2) begin
                    check("lsb_done_pos2", 64'(j), 64'd35);
                    check("lsb_frame2", 64'(g_mdl[1].q[7:0]), 64'(rev8(d2)));
                end
            end
        end
        check("lsb_busy_cycles", 64'(nbusy), 64'd36);
        check("lsb_frame_count", 64'(ndone), 64'd2);
        check("lsb_back_idle", 64'(busy_v[1]), 64'd0);

        // reset during bit 7 of a frame
        wait_done(0, "done_pre_reset");
        repeat (30) @(negedge clk);
        check("pre_reset_busy", 64'(busy_v[0]), 64'd1);
        lat0 = g_mdl[0].latches;
        rst_n = 1'b0;
        #1;
        check("reset_async", ovec(0), IDLE_VEC);
        repeat (3) @(negedge clk);
        check("reset_held", ovec(0), IDLE_VEC);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("post_reset_idle", ovec(0), IDLE_VEC);
        end
        check("no_partial_latch", 64'(g_mdl[0].latches - lat0), 64'd0);

        // random words; refresh mode shows a new word two frames after its load
        @(negedge clk);
        din2 = 1'($urandom);
        din3 = 16'($urandom);
        din4 = {$urandom, $urandom};
        exp2.push_back(64'(din2));
        exp3.push_back(64'(din3));
        exp3.push_back(64'(din3));
        exp4.push_back(din4);
        exp4.push_back(din4);
        load_v[4:2] = 3'b111;
        n2 = 0; n3 = 0; n4 = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            load_v[4:2] = 3'b000;
            if (done_v[2]) begin
                check("model_n1", 64'(g_mdl[2].q[0]), exp2.pop_front());
                n2++;
                din2 = 1'($urandom);
                exp2.push_back(64'(din2));
                load_v[2] = 1'b1;
            end
            if (done_v[3]) begin
                check("model_n16", 64'(g_mdl[3].q[15:0]), exp3.pop_front());
                n3++;
                din3 = 16'($urandom);
                exp3.push_back(64'(din3));
                load_v[3] = 1'b1;
            end
            if (done_v[4]) begin
                check("model_n64", g_mdl[4].q, exp4.pop_front());
                n4++;
                din4 = {$urandom, $urandom};
                exp4.push_back(din4);
                load_v[4] = 1'b1;
            end
        end
        load_v = '0;
        check("frames_n1", 64'(n2 >= 500), 64'd1);
        check("frames_n16", 64'(n3 >= 25), 64'd1);
        check("frames_n64", 64'(n4 >= 20), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
